// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control-unit definitions: machine-cycle state encoding and default beat-bus width.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_INT   = 2'd3
  } state_t;

  localparam int N_T_DEFAULT = 4;

endpackage

// File: rtl/cycle_sequencer_beat_decoder.sv
// Turns the binary beat counter into the one-hot beat bus; forced to zero while idle.
module beat_decoder #(
  parameter int N_T   = 4,
  parameter int LEN_W = 3
) (
  input  logic [LEN_W-1:0] cnt_i,
  input  logic             busy_i,
  output logic [N_T-1:0]   t_o
);

  always_comb begin
    t_o = '0;
    if (busy_i) t_o = N_T'(1) << cnt_i;
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Machine-cycle / beat sequencer: FETCH, variable-length EXEC and INTERRUPT cycles with one-hot beat strobes.
module cycle_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int  N_T       = N_T_DEFAULT,
  parameter int  IF_BEATS  = 2,
  parameter int  INT_BEATS = 2,
  localparam int LEN_W     = $clog2(N_T + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             stop,
  input  logic             done,
  input  logic [LEN_W-1:0] ex_len,
  input  logic             step,
  input  logic             irq,
  input  logic             irq_en,
  output logic             Mif,
  output logic             Mex,
  output logic             Mint,
  output logic [N_T-1:0]   T,
  output logic [LEN_W-1:0] beat,
  output logic             busy,
  output logic             instr_end,
  output logic             irq_ack,
  output state_t           state_dbg
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             instr_end_q, instr_end_d;
  logic             irq_ack_q, irq_ack_d;
  logic             fin;
  logic [LEN_W-1:0] len_clamp;

  assign len_clamp = (int'(ex_len) > N_T) ? LEN_W'(N_T) : ex_len;

  // Beats advance only when done=1; without it the state and counter simply hold.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    instr_end_d = 1'b0;
    irq_ack_d   = 1'b0;
    fin         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        if (done) begin
          if (int'(cnt_q) < IF_BEATS - 1) begin
            cnt_d = cnt_q + 1'b1;
          end else if (stop) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            len_d = len_clamp;
            if (len_clamp == '0) begin
              fin = 1'b1;
            end else begin
              state_d = S_EXEC;
              cnt_d   = '0;
            end
          end
        end
      end
      S_EXEC: begin
        if (done) begin
          if (int'(cnt_q) < int'(len_q) - 1) cnt_d = cnt_q + 1'b1;
          else fin = 1'b1;
        end
      end
      S_INT: begin
        if (done) begin
          if (int'(cnt_q) < INT_BEATS - 1) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            instr_end_d = 1'b1;
            state_d     = step ? S_IDLE : S_FETCH;
            cnt_d       = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // End of instruction: a pending enabled interrupt takes precedence over single-step.
    if (fin) begin
      instr_end_d = 1'b1;
      cnt_d       = '0;
      if (irq && irq_en) begin
        state_d   = S_INT;
        irq_ack_d = 1'b1;
      end else if (step) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      instr_end_q <= 1'b0;
      irq_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      instr_end_q <= instr_end_d;
      irq_ack_q   <= irq_ack_d;
    end
  end

  assign Mif       = (state_q == S_FETCH);
  assign Mex       = (state_q == S_EXEC);
  assign Mint      = (state_q == S_INT);
  assign busy      = (state_q != S_IDLE);
  assign beat      = cnt_q;
  assign instr_end = instr_end_q;
  assign irq_ack   = irq_ack_q;
  assign state_dbg = state_q;

  beat_decoder #(
    .N_T  (N_T),
    .LEN_W(LEN_W)
  ) u_beat_decoder (
    .cnt_i (cnt_q),
    .busy_i(busy),
    .t_o   (T)
  );

endmodule
